pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 9 +
 rtl/hazard_detect.sv | 29 ++
 rtl/pipe_ctrl.sv | 79 +++++++
 tb/tb_pipe_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, memory FSM encoding and saturating-count helper.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_LEN = 4;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_WAIT = 2'd1, ST_ERROR = 2'd2} mem_state_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: RAW hazard compare of ID sources against EX/MEM destinations.
// FORWARDING_EN defined: only EX load-use hazards stall; MEM results are forwarded.
module hazard_detect #(
    parameter int AW = pipe_ctrl_pkg::REG_ADDR_LEN
) (
    input  logic [AW-1:0] i_src1,
    input  logic [AW-1:0] i_src2,
    input  logic          i_two_src,
    input  logic          i_exe_wb_en,
    input  logic [AW-1:0] i_exe_dest,
    input  logic          i_exe_mem_r_en,
    input  logic          i_mem_wb_en,
    input  logic [AW-1:0] i_mem_dest,
    output logic          o_hit
);
    logic w_ex;
    logic w_mem;
    assign w_ex  = i_exe_wb_en && (i_src1 == i_exe_dest || (i_two_src && i_src2 == i_exe_dest));
    assign w_mem = i_mem_wb_en && (i_src1 == i_mem_dest || (i_two_src && i_src2 == i_mem_dest));
`ifdef FORWARDING_EN
    logic w_unused;
    assign w_unused = w_mem;
    assign o_hit = w_ex && i_exe_mem_r_en;
`else
    logic w_unused;
    assign w_unused = i_exe_mem_r_en;
    assign o_hit = w_ex || w_mem;
`endif
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/flush/freeze control with SRAM wait FSM and stall/flush counters.
// Optional FORWARDING_EN macro restricts stalls to EX load-use hazards.
module pipe_ctrl #(
    parameter int REG_ADDR_LEN = pipe_ctrl_pkg::REG_ADDR_LEN,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] src1,
    input  logic [REG_ADDR_LEN-1:0] src2,
    input  logic                    two_src,
    input  logic                    exe_wb_en,
    input  logic [REG_ADDR_LEN-1:0] exe_dest,
    input  logic                    exe_mem_r_en,
    input  logic                    mem_wb_en,
    input  logic [REG_ADDR_LEN-1:0] mem_dest,
    input  logic                    branch_taken,
    input  logic                    mem_req,
    input  logic                    sram_ready,
    output logic                    freeze_if,
    output logic                    bubble_id,
    output logic                    flush,
    output logic                    freeze_all,
    output logic                    mem_timeout,
    output logic [15:0]             stall_cnt,
    output logic [15:0]             flush_cnt
);
    import pipe_ctrl_pkg::*;
    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
    logic             w_hit;
    logic             w_freeze_all;
    mem_state_t       r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    hazard_detect #(.AW(REG_ADDR_LEN)) u_hazard (
        .i_src1(src1), .i_src2(src2), .i_two_src(two_src),
        .i_exe_wb_en(exe_wb_en), .i_exe_dest(exe_dest), .i_exe_mem_r_en(exe_mem_r_en),
        .i_mem_wb_en(mem_wb_en), .i_mem_dest(mem_dest), .o_hit(w_hit)
    );
    // rst gating keeps every control output low while reset is held
    assign w_freeze_all = rst && (r_state == ST_ERROR || (mem_req && !sram_ready));
    assign freeze_all   = w_freeze_all;
    assign flush        = rst && branch_taken && !w_freeze_all;
    assign freeze_if    = rst && w_hit && !w_freeze_all && !branch_taken;
    assign bubble_id    = freeze_if;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_stall_cnt <= sat_inc(r_stall_cnt, freeze_if || w_freeze_all);
            r_flush_cnt <= sat_inc(r_flush_cnt, flush);
            case (r_state)
                ST_RUN: if (mem_req && !sram_ready) begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= 8'd1;
                end
                ST_WAIT: if (sram_ready || !mem_req) begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end else if (r_wait_cnt == TIMEOUT) begin
                    r_state       <= ST_ERROR;
                    r_mem_timeout <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                default: r_state <= ST_ERROR;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven vectors plus multi-cycle sequences, checked through an expectation queue.
module tb_pipe_ctrl;
    localparam int AW = 4;
    localparam int TO = 4;
`ifdef FORWARDING_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [AW-1:0] src1, src2, exe_dest, mem_dest;
    logic two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_req, sram_ready;
    logic freeze_if, bubble_id, flush, freeze_all, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;
    always #5 clk = ~clk;
    pipe_ctrl #(.REG_ADDR_LEN(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_r_en(exe_mem_r_en),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .branch_taken(branch_taken),
        .mem_req(mem_req), .sram_ready(sram_ready), .freeze_if(freeze_if), .bubble_id(bubble_id),
        .flush(flush), .freeze_all(freeze_all), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
    typedef struct {
        string name;
        logic [AW-1:0] s1, s2;
        logic two, ewb;
        logic [AW-1:0] ed;
        logic emr, mwb;
        logic [AW-1:0] md;
        logic br, mreq, rdy;
        logic fi, fl, fa;
    } vec_t;
    typedef struct {
        string name;
        logic fi, fl, fa, to;
        logic [15:0] sc, fc;
    } exp_t;
    exp_t q[$];
    vec_t vt[12];
    int checks = 0;
    int failures = 0;
    int m_st = 0;
    int m_wait = 0;
    logic m_to = 1'b0;
    int m_sc = 0;
    int m_fc = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        src1 = v.s1; src2 = v.s2; two_src = v.two; exe_wb_en = v.ewb; exe_dest = v.ed;
        exe_mem_r_en = v.emr; mem_wb_en = v.mwb; mem_dest = v.md; branch_taken = v.br;
        mem_req = v.mreq; sram_ready = v.rdy;
    endtask

    task automatic model_reset();
        m_st = 0; m_wait = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    task automatic step_exp(input string name, input logic fi, input logic fl, input logic fa);
        exp_t e;
        exp_t g;
        if (!rst) model_reset();
        e.name = name; e.to = m_to; e.sc = 16'(m_sc); e.fc = 16'(m_fc);
        e.fi = rst ? fi : 1'b0; e.fl = rst ? fl : 1'b0; e.fa = rst ? fa : 1'b0;
        q.push_back(e);
        #2;
        g = q.pop_front();
        cmp({g.name, ".freeze_if"}, 16'(freeze_if), 16'(g.fi));
        cmp({g.name, ".bubble_id"}, 16'(bubble_id), 16'(g.fi));
        cmp({g.name, ".flush"}, 16'(flush), 16'(g.fl));
        cmp({g.name, ".freeze_all"}, 16'(freeze_all), 16'(g.fa));
        cmp({g.name, ".mem_timeout"}, 16'(mem_timeout), 16'(g.to));
        cmp({g.name, ".stall_cnt"}, stall_cnt, g.sc);
        cmp({g.name, ".flush_cnt"}, flush_cnt, g.fc);
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            if ((e.fi || e.fa) && m_sc < 65535) m_sc++;
            if (e.fl && m_fc < 65535) m_fc++;
            if (m_st == 0 && mem_req && !sram_ready) begin m_st = 1; m_wait = 1; end
            else if (m_st == 1) begin
                if (sram_ready || !mem_req) begin m_st = 0; m_wait = 0; end
                else if (m_wait == TO) begin m_st = 2; m_to = 1'b1; end
                else m_wait++;
            end
        end
        @(negedge clk);
    endtask

    task automatic step_model(input string name);
        logic hit, fa;
        if (FW) hit = exe_mem_r_en && exe_wb_en && (src1 == exe_dest || (two_src && src2 == exe_dest));
        else hit = (exe_wb_en && (src1 == exe_dest || (two_src && src2 == exe_dest))) ||
                   (mem_wb_en && (src1 == mem_dest || (two_src && src2 == mem_dest)));
        fa = (m_st == 2) || (mem_req && !sram_ready);
        step_exp(name, hit && !fa && !branch_taken, branch_taken && !fa, fa);
    endtask

    initial begin
        vec_t z;
        z = '{name: "z", s1: 1, s2: 2, two: 1, ewb: 0, ed: 0, emr: 0, mwb: 0, md: 0,
              br: 0, mreq: 0, rdy: 0, fi: 0, fl: 0, fa: 0};
        vt[0] = z; vt[0].name = "idle";
        vt[1] = z; vt[1].name = "ex_src1"; vt[1].s1 = 3; vt[1].ed = 3; vt[1].ewb = 1; vt[1].fi = !FW;
        vt[2] = vt[1]; vt[2].name = "ex_src1_load"; vt[2].emr = 1; vt[2].fi = 1;
        vt[3] = z; vt[3].name = "ex_src2_load"; vt[3].s2 = 5; vt[3].ed = 5; vt[3].ewb = 1; vt[3].emr = 1; vt[3].fi = 1;
        vt[4] = vt[3]; vt[4].name = "ex_src2_unused"; vt[4].two = 0; vt[4].fi = 0;
        vt[5] = z; vt[5].name = "mem_src1"; vt[5].s1 = 7; vt[5].md = 7; vt[5].mwb = 1; vt[5].fi = !FW;
        vt[6] = vt[5]; vt[6].name = "mem_no_wb"; vt[6].mwb = 0; vt[6].fi = 0;
        vt[7] = vt[2]; vt[7].name = "ex_no_wb"; vt[7].ewb = 0; vt[7].fi = 0;
        vt[8] = vt[2]; vt[8].name = "branch_hazard"; vt[8].br = 1; vt[8].fi = 0; vt[8].fl = 1;
        vt[9] = z; vt[9].name = "branch_only"; vt[9].br = 1; vt[9].fl = 1;
        vt[10] = vt[2]; vt[10].name = "mem_ready"; vt[10].mreq = 1; vt[10].rdy = 1;
        vt[11] = z; vt[11].name = "mem_src2"; vt[11].s2 = 9; vt[11].md = 9; vt[11].mwb = 1; vt[11].fi = !FW;
        drive(z);
        @(negedge clk);
        drive(vt[8]); mem_req = 1'b1;
        step_exp("reset_hold", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(z);
        step_exp("after_reset", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(vt[i]);
            step_exp(vt[i].name, vt[i].fi, vt[i].fl, vt[i].fa);
        end
        drive(vt[2]); mem_req = 1'b1; sram_ready = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) step_model("sram_wait");
        sram_ready = 1'b1;
        step_model("sram_release");
        drive(z);
        step_model("post_wait");
        mem_req = 1'b1; sram_ready = 1'b0;
        for (int i = 0; i < 7; i++) step_model("timeout");
        mem_req = 1'b0; sram_ready = 1'b1; branch_taken = 1'b1;
        step_model("error_sticky");
        rst = 1'b0;
        step_exp("error_reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(z);
        step_model("error_cleared");
        drive(vt[2]);
        repeat (70000) @(posedge clk);
        m_sc = (m_sc + 70000 > 65535) ? 65535 : m_sc + 70000;
        @(negedge clk);
        step_model("stall_sat");
        step_model("stall_sat_hold");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
